aes_word_loader: RTL and testbench

Upstream input stage for the combinational AES-128 cipher (`aescipher`). It accepts the cipher key and plaintext as a stream of 16-bit words over a valid/ready handshake and assembles them into 128-bit `key` and `datain` vectors. It presents each completed block to the cipher with a valid/ready handshake. A loaded key can be retained and reused across blocks, so only plaintext words need to be streamed.

---
 rtl/aes_pkg.sv | 17 +
 rtl/aes_word_shreg.sv | 28 ++
 rtl/aes_word_loader.sv | 120 ++++++++++++
 tb/tb_aes_word_loader.sv | 232 +++++++++++++++++++++++
 4 files changed

// File: rtl/aes_pkg.sv
// Shared constants and state type for the AES input loader.
//   AES_BLK_W  : width of one AES key or data block
//   AES_WORD_W : width of one streamed input word
//   AES_WORDS  : words per block
package aes_pkg;

  localparam int unsigned AES_BLK_W  = 128;
  localparam int unsigned AES_WORD_W = 16;
  localparam int unsigned AES_WORDS  = 8;

  typedef enum logic [1:0] {
    LOAD_KEY  = 2'd0,
    LOAD_DATA = 2'd1,
    PRESENT   = 2'd2
  } aes_ld_state_t;

endpackage

// File: rtl/aes_word_shreg.sv
// Block-wide shift-in register; each enabled cycle appends one word at the
// LSB end so the first word shifted in ends up in the top word position.
//   clk, rst_n : clock, async active-low reset (clears contents)
//   en         : shift in word this cycle
//   word       : incoming word
//   q          : register contents
module aes_word_shreg
  import aes_pkg::*;
#(
  parameter int unsigned BLK_W  = AES_BLK_W,
  parameter int unsigned WORD_W = AES_WORD_W
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              en,
  input  logic [WORD_W-1:0] word,
  output logic [BLK_W-1:0]  q
);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      q <= '0;
    end else if (en) begin
      q <= {q[BLK_W-WORD_W-1:0], word};
    end
  end

endmodule

// File: rtl/aes_word_loader.sv
// Streams 16-bit words into a 128-bit AES key and plaintext block and
// presents the completed block to the cipher. The key can be kept for the
// next block so only plaintext words need to be streamed.
//   clk, rst_n          : clock, async active-low reset
//   in_valid/in_ready   : input word handshake
//   in_word             : key or data word, most-significant word first
//   key_keep            : on output handshake, reuse key for next block
//   blk_valid/blk_ready : output block handshake
//   blk_key, blk_data   : assembled key and plaintext
module aes_word_loader
  import aes_pkg::*;
#(
  parameter int unsigned WORD_W = AES_WORD_W,
  parameter int unsigned WORDS  = AES_WORDS
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     in_valid,
  output logic                     in_ready,
  input  logic [WORD_W-1:0]        in_word,
  input  logic                     key_keep,
  output logic                     blk_valid,
  input  logic                     blk_ready,
  output logic [WORD_W*WORDS-1:0]  blk_key,
  output logic [WORD_W*WORDS-1:0]  blk_data
);

  localparam int unsigned BLK_W = WORD_W * WORDS;
  localparam int unsigned CNT_W = $clog2(WORDS);

  aes_ld_state_t    state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             accept_c;
  logic             last_c;
  logic             key_en_c;
  logic             data_en_c;

  assign accept_c = in_valid && in_ready;
  assign last_c   = (cnt_q == CNT_W'(WORDS - 1));

  // Next-state, word counter and shift enables.
  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    key_en_c  = 1'b0;
    data_en_c = 1'b0;
    case (state_q)
      LOAD_KEY: begin
        if (accept_c) begin
          key_en_c = 1'b1;
          if (last_c) begin
            state_d = LOAD_DATA;
            cnt_d   = '0;
          end else begin
            cnt_d = cnt_q + CNT_W'(1);
          end
        end
      end
      LOAD_DATA: begin
        if (accept_c) begin
          data_en_c = 1'b1;
          if (last_c) begin
            state_d = PRESENT;
            cnt_d   = '0;
          end else begin
            cnt_d = cnt_q + CNT_W'(1);
          end
        end
      end
      PRESENT: begin
        if (blk_ready) begin
          state_d = key_keep ? LOAD_DATA : LOAD_KEY;
        end
      end
      default: begin
        state_d = LOAD_KEY;
        cnt_d   = '0;
      end
    endcase
  end

  // State register; handshake flags are registered from the next state so
  // they always match the state they describe.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= LOAD_KEY;
      cnt_q     <= '0;
      in_ready  <= 1'b1;
      blk_valid <= 1'b0;
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      in_ready  <= (state_d != PRESENT);
      blk_valid <= (state_d == PRESENT);
    end
  end

  aes_word_shreg #(
    .BLK_W  (BLK_W),
    .WORD_W (WORD_W)
  ) u_key_sr (
    .clk   (clk),
    .rst_n (rst_n),
    .en    (key_en_c),
    .word  (in_word),
    .q     (blk_key)
  );

  aes_word_shreg #(
    .BLK_W  (BLK_W),
    .WORD_W (WORD_W)
  ) u_data_sr (
    .clk   (clk),
    .rst_n (rst_n),
    .en    (data_en_c),
    .word  (in_word),
    .q     (blk_data)
  );

endmodule

// File: tb/tb_aes_word_loader.sv
// Self-checking bench for aes_word_loader: a word-queue model predicts the
// handshake flags and block contents every cycle; directed literal checks
// pin the FIPS-197 vectors, key reuse, backpressure, reload and reset.
module tb_aes_word_loader;

  logic         clk = 1'b0;
  logic         rst_n = 1'b0;
  logic         in_valid = 1'b0;
  logic         in_ready;
  logic [15:0]  in_word = '0;
  logic         key_keep = 1'b0;
  logic         blk_valid;
  logic         blk_ready = 1'b0;
  logic [127:0] blk_key;
  logic [127:0] blk_data;

  int n_cmp = 0;
  int n_bad = 0;

  aes_word_loader dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_word   (in_word),
    .key_keep  (key_keep),
    .blk_valid (blk_valid),
    .blk_ready (blk_ready),
    .blk_key   (blk_key),
    .blk_data  (blk_data)
  );

  always #5 clk = ~clk;

  // ---------------- model ----------------
  logic [15:0]  mq[$];
  bit           m_need_key;
  bit           m_present;
  logic [127:0] m_key;
  logic [127:0] m_data;

  function automatic logic [127:0] pack8(input int start);
    logic [127:0] r;
    r = '0;
    for (int i = 0; i < 8; i++) r[127-16*i -: 16] = mq[start+i];
    return r;
  endfunction

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      mq.delete();
      m_need_key = 1'b1;
      m_present  = 1'b0;
    end else if (m_present) begin
      if (blk_ready) begin
        m_present  = 1'b0;
        m_need_key = !key_keep;
      end
    end else if (in_valid) begin
      mq.push_back(in_word);
      if (mq.size() == (m_need_key ? 16 : 8)) begin
        if (m_need_key) begin
          m_key  = pack8(0);
          m_data = pack8(8);
        end else begin
          m_data = pack8(0);
        end
        m_present = 1'b1;
        mq.delete();
      end
    end
  end

  task automatic check1(input string name, input logic [127:0] act, input logic [127:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // Per-cycle compare against the model, away from the active edge.
  always @(negedge clk) begin
    if (rst_n) begin
      check1("in_ready", 128'(in_ready), 128'(!m_present));
      check1("blk_valid", 128'(blk_valid), 128'(m_present));
      if (m_present) begin
        check1("blk_key", blk_key, m_key);
        check1("blk_data", blk_data, m_data);
      end
    end
  end

  // ---------------- driver ----------------
  // All tasks start and end just after a falling edge.
  task automatic beat(input logic [15:0] w, input int gaps);
    int t;
    repeat (gaps) begin
      in_valid = 1'b0;
      @(negedge clk);
    end
    in_valid = 1'b1;
    in_word  = w;
    t = 0;
    while (!in_ready && t < 50) begin
      @(negedge clk);
      t++;
    end
    if (!in_ready) begin
      n_cmp++;
      n_bad++;
      $display("FAIL beat_timeout: in_ready stayed %b, required 1", in_ready);
    end
    @(negedge clk);
    in_valid = 1'b0;
  endtask

  task automatic wait_valid();
    int t;
    t = 0;
    while (!blk_valid && t < 50) begin
      @(negedge clk);
      t++;
    end
    check1("wait_valid", 128'(blk_valid), 128'(1));
  endtask

  task automatic handshake(input logic keep);
    blk_ready = 1'b1;
    key_keep  = keep;
    @(negedge clk);
    blk_ready = 1'b0;
    key_keep  = 1'b0;
  endtask

  task automatic fips_words(input bit sparse);
    for (int i = 0; i < 8; i++)
      beat({4'(2*i), 4'h0, 4'(2*i+1)} & 16'h0f0f | 16'h0000, sparse ? int'($urandom_range(0, 1)) : 0);
    for (int i = 0; i < 8; i++)
      beat({4'(2*i), 4'(2*i), 4'(2*i+1), 4'(2*i+1)}, sparse ? int'($urandom_range(0, 1)) : 0);
  endtask

  localparam logic [127:0] FIPS_KEY  = 128'h000102030405060708090a0b0c0d0e0f;
  localparam logic [127:0] FIPS_DATA = 128'h00112233445566778899aabbccddeeff;

  initial begin
    // Reset state.
    #12;
    check1("rst_in_ready", 128'(in_ready), 128'(1));
    check1("rst_blk_valid", 128'(blk_valid), 128'(0));
    check1("rst_blk_key", blk_key, '0);
    check1("rst_blk_data", blk_data, '0);
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);

    // FIPS-197 load with blk_ready held high; keep the key at the handshake.
    blk_ready = 1'b1;
    fips_words(1'b0);
    check1("fips_valid_latency", 128'(blk_valid), 128'(1));
    check1("fips_key", blk_key, FIPS_KEY);
    check1("fips_data", blk_data, FIPS_DATA);
    key_keep = 1'b1;
    @(negedge clk);
    key_keep = 1'b0;
    check1("fips_valid_one_cycle", 128'(blk_valid), 128'(0));

    // Key reuse: 8 zero words; hold the block for backpressure.
    blk_ready = 1'b0;
    for (int i = 0; i < 8; i++) beat(16'h0000, 0);
    check1("reuse_valid", 128'(blk_valid), 128'(1));
    check1("reuse_key", blk_key, FIPS_KEY);
    check1("reuse_data", blk_data, '0);

    // Backpressure with a pending word, then reload key with all ones.
    in_valid = 1'b1;
    in_word  = 16'hffff;
    repeat (10) begin
      check1("bp_in_ready", 128'(in_ready), 128'(0));
      @(negedge clk);
    end
    check1("bp_key_stable", blk_key, FIPS_KEY);
    check1("bp_data_stable", blk_data, '0);
    handshake(1'b0);
    check1("bp_ready_after_hs", 128'(in_ready), 128'(1));
    @(negedge clk);  // pending 0xffff accepted here as key word 0
    in_valid = 1'b0;
    for (int i = 1; i < 8; i++) beat(16'hffff, 0);
    for (int i = 0; i < 8; i++) beat(16'h1000 + 16'(i), 0);
    wait_valid();
    check1("reload_key", blk_key, {128{1'b1}});
    check1("reload_data", blk_data, 128'h10001001100210031004100510061007);
    handshake(1'b0);

    // Sparse input reproduces the FIPS block.
    fips_words(1'b1);
    wait_valid();
    check1("sparse_key", blk_key, FIPS_KEY);
    check1("sparse_data", blk_data, FIPS_DATA);
    handshake(1'b0);

    // Reset after 3 data beats.
    for (int i = 0; i < 8; i++) beat(16'h5555, 0);
    for (int i = 0; i < 3; i++) beat(16'h6666, 0);
    #2 rst_n = 1'b0;
    #1;
    check1("mid_rst_in_ready", 128'(in_ready), 128'(1));
    check1("mid_rst_blk_valid", 128'(blk_valid), 128'(0));
    check1("mid_rst_blk_key", blk_key, '0);
    check1("mid_rst_blk_data", blk_data, '0);
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    for (int i = 0; i < 8; i++) beat(16'ha000 + 16'(i), 0);
    for (int i = 0; i < 8; i++) beat(16'hb0b0 + 16'(i), 0);
    wait_valid();
    check1("post_rst_key", blk_key, 128'ha000a001a002a003a004a005a006a007);
    check1("post_rst_data", blk_data, 128'hb0b0b0b1b0b2b0b3b0b4b0b5b0b6b0b7);
    handshake(1'b1);
    repeat (3) @(negedge clk);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL global_timeout: simulation did not complete");
    $fatal(1);
  end

endmodule
